// File: rtl/score_keeper.sv
// Round-robin add-points arbiter with a 3-digit packed-BCD score register.
// Ports: clk, reset_n, req_i/pts_i in, ack_o out, clr_i in, score_o/busy_o/done_o/ovf_o out. Macro: SCORE_KEEPER_SAT_EN.
module score_keeper #(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] pts_i,
  output logic [N_REQ-1:0]   ack_o,
  input  logic               clr_i,
  output logic [11:0]        score_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, GRANT, ADD0, ADD1, ADD2
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant_idx;
  logic [7:0]      op;
  logic [11:0]     work;
  logic            carry;

  logic            any_req;
  logic            hi_any;
  logic [IW-1:0]   hi_idx;
  logic [IW-1:0]   lo_idx;
  logic [IW-1:0]   win_idx;
  logic [7:0]      sel_pts;
  logic [3:0]      wd;
  logic [3:0]      od;
  logic [4:0]      sum;
  logic [3:0]      dig;
  logic            cout;

  function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {hi, lo};
  endfunction

  // Descending scan leaves the lowest matching index; requesters
  // above last_grant take precedence, else wrap to the lowest.
  always_comb begin
    any_req = 1'b0;
    hi_any  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        any_req = 1'b1;
        lo_idx  = IW'(k);
        if (k > int'(last_grant)) begin
          hi_any = 1'b1;
          hi_idx = IW'(k);
        end
      end
    end
    win_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_pts = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IW'(k)) sel_pts = pts_i[8*k +: 8];
    end
  end

  always_comb begin
    wd = 4'd0;
    od = 4'd0;
    unique case (state)
      ADD0: begin
        wd = work[3:0];
        od = op[3:0];
      end
      ADD1: begin
        wd = work[7:4];
        od = op[7:4];
      end
      ADD2: wd = work[11:8];
      default: ;
    endcase
    sum = {1'b0, wd} + {1'b0, od} + {4'd0, carry};
    if (sum > 5'd9) begin
      dig  = 4'(sum - 5'd10);
      cout = 1'b1;
    end else begin
      dig  = sum[3:0];
      cout = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (!clr_i && any_req) state_n = GRANT;
      GRANT:   state_n = ADD0;
      ADD0:    state_n = ADD1;
      ADD1:    state_n = ADD2;
      ADD2:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= IW'(N_REQ - 1);
      grant_idx  <= '0;
      op         <= '0;
      work       <= '0;
      carry      <= 1'b0;
      ack_o      <= '0;
      score_o    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      ovf_o      <= 1'b0;
    end else begin
      ack_o  <= '0;
      done_o <= 1'b0;
      busy_o <= (state_n != IDLE);
      unique case (state)
        IDLE: begin
          if (clr_i) begin
            score_o <= '0;
            ovf_o   <= 1'b0;
          end else if (any_req) begin
            ack_o     <= N_REQ'(1) << win_idx;
            grant_idx <= win_idx;
          end
        end
        GRANT: begin
          op         <= clamp_bcd(sel_pts);
          work       <= score_o;
          carry      <= 1'b0;
          last_grant <= grant_idx;
        end
        ADD0: begin
          work[3:0] <= dig;
          carry     <= cout;
        end
        ADD1: begin
          work[7:4] <= dig;
          carry     <= cout;
        end
        ADD2: begin
          done_o <= 1'b1;
          if (cout) begin
            ovf_o <= 1'b1;
`ifdef SCORE_KEEPER_SAT_EN
            score_o <= 12'h999;
`else
            score_o <= {dig, work[7:0]};
`endif
          end else begin
            score_o <= {dig, work[7:0]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: table of add/clear vectors
// plus hand sequences for fairness, clear priority, overflow, reset.
module tb_score_keeper;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [8*N-1:0] pts;
  logic [N-1:0]  ack;
  logic          clr;
  logic [11:0]   score;
  logic          busy;
  logic          done;
  logic          ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] cur;

  typedef struct {
    logic        clr;
    int          r;
    logic [7:0]  p;
    logic [11:0] s;
    logic        o;
  } vec_t;

  vec_t tbl[9];

  score_keeper #(.N_REQ(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req_i   (req),
    .pts_i   (pts),
    .ack_o   (ack),
    .clr_i   (clr),
    .score_o (score),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_add(input int r, input logic [7:0] p,
                        input logic [11:0] es, input logic eo);
    @(negedge clk);
    req = N'(1) << r;
    pts = 16'(p) << (8 * r);
    @(negedge clk);
    chk("ack", 16'(ack), 16'(N'(1) << r));
    chk("busy_hi", 16'(busy), 16'd1);
    req = '0;
    repeat (3) begin
      @(negedge clk);
      chk("ack_pulse", 16'(ack), 16'd0);
      chk("score_held", 16'(score), 16'(cur));
      chk("done_early", 16'(done), 16'd0);
    end
    @(negedge clk);
    chk("done", 16'(done), 16'd1);
    chk("score", 16'(score), 16'(es));
    chk("ovf", 16'(ovf), 16'(eo));
    chk("busy_lo", 16'(busy), 16'd0);
    cur = es;
    @(negedge clk);
    chk("done_pulse", 16'(done), 16'd0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("clr_score", 16'(score), 16'd0);
    chk("clr_ovf", 16'(ovf), 16'd0);
    chk("clr_ack", 16'(ack), 16'd0);
    chk("clr_busy", 16'(busy), 16'd0);
    clr = 1'b0;
    cur = '0;
  endtask

  task automatic run_ovf();
    logic [11:0] e1;
    logic [11:0] e2;
`ifdef SCORE_KEEPER_SAT_EN
    e1 = 12'h999;
    e2 = 12'h999;
`else
    e1 = 12'h015;
    e2 = 12'h016;
`endif
    do_clear();
    for (int k = 1; k <= 10; k++) do_add(0, 8'h99, to_bcd(99 * k), 1'b0);
    do_add(1, 8'h25, e1, 1'b1);
    do_add(0, 8'h01, e2, 1'b1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 0, 8'h47, 12'h051, 1'b0};
    tbl[1] = '{1'b0, 0, 8'h44, 12'h095, 1'b0};
    tbl[2] = '{1'b0, 1, 8'h07, 12'h102, 1'b0};
    tbl[3] = '{1'b1, 0, 8'h00, 12'h000, 1'b0};
    tbl[4] = '{1'b0, 0, 8'h0F, 12'h009, 1'b0};
    tbl[5] = '{1'b0, 1, 8'h99, 12'h108, 1'b0};
    tbl[6] = '{1'b0, 0, 8'hFA, 12'h207, 1'b0};
    tbl[7] = '{1'b0, 1, 8'h93, 12'h300, 1'b0};
    tbl[8] = '{1'b0, 0, 8'hAB, 12'h399, 1'b0};

    reset_n = 1'b0;
    req = '0;
    pts = '0;
    clr = 1'b0;
    cur = '0;
    repeat (2) @(negedge clk);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_ack", 16'(ack), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    reset_n = 1'b1;

    // Fairness: both held, grants alternate every 5 cycles from 0.
    @(negedge clk);
    req = 2'b11;
    pts = 16'h0101;
    for (int c = 0; c < 16; c++) begin
      logic [N-1:0] ea;
      @(negedge clk);
      ea = '0;
      if (c % 5 == 0) ea = ((c / 5) % 2 == 1) ? 2'b10 : 2'b01;
      chk("rr_ack", 16'(ack), 16'(ea));
      if (c == 15) req = '0;
    end
    repeat (4) @(negedge clk);
    chk("rr_done", 16'(done), 16'd1);
    chk("rr_score", 16'(score), 16'h004);
    cur = 12'h004;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].clr) do_clear();
      else do_add(tbl[i].r, tbl[i].p, tbl[i].s, tbl[i].o);
    end

    // Clear beats a simultaneous request; the request wins next.
    @(negedge clk);
    clr = 1'b1;
    req = 2'b10;
    pts = 16'h1200;
    @(negedge clk);
    chk("cp_score", 16'(score), 16'd0);
    chk("cp_noack", 16'(ack), 16'd0);
    clr = 1'b0;
    cur = '0;
    @(negedge clk);
    chk("cp_ack", 16'(ack), 16'h2);
    req = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    chk("cp_done", 16'(done), 16'd1);
    chk("cp_res", 16'(score), 16'h012);
    cur = 12'h012;

    run_ovf();
    do_clear();
    do_add(0, 8'h11, 12'h011, 1'b0);
    run_ovf();

    // Reset during ADD1 discards the add and clears everything.
    @(negedge clk);
    req = 2'b01;
    pts = 16'h0022;
    @(negedge clk);
    chk("mr_ack", 16'(ack), 16'h1);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mr_score", 16'(score), 16'd0);
    chk("mr_ack0", 16'(ack), 16'd0);
    chk("mr_busy", 16'(busy), 16'd0);
    chk("mr_done", 16'(done), 16'd0);
    chk("mr_ovf", 16'(ovf), 16'd0);
    reset_n = 1'b1;
    cur = '0;
    repeat (6) begin
      @(negedge clk);
      chk("mr_nodone", 16'(done), 16'd0);
      chk("mr_hold", 16'(score), 16'd0);
    end
    do_add(1, 8'h05, 12'h005, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
